// File: rtl/perm_shuffle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perm_shuffle_pkg
//  Description : Shared constants, FSM encoding and helpers for the
//                multi-round lane-permutation engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package perm_shuffle_pkg;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'h0001;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = C_ST_IDLE,
        RUN  = C_ST_RUN,
        DONE = C_ST_DONE
    } state_e;

    // lanes is a power of two, so the modulo reduces to a mask.
    function automatic int unsigned lane_idx(
        input int unsigned m,
        input int unsigned k,
        input int unsigned i,
        input int unsigned lanes
    );
        return (m * i + k) & (lanes - 1);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/perm_affine_round.sv
`default_nettype none
// ============================================================================
//  Module      : perm_affine_round
//  Description : One combinational keyed affine lane permutation:
//                out lane i = in lane ((m*i + k) mod LANES).
//  Revision    : 1.0 - initial release
// ============================================================================
module perm_affine_round
    import perm_shuffle_pkg::*;
#(
    parameter  int LANES  = 16,
    parameter  int LANE_W = 4,
    localparam int LOG2L  = $clog2(LANES)
) (
    input  logic [LANES*LANE_W-1:0] word_in,
    input  logic [LOG2L-1:0]        mult,
    input  logic [LOG2L-1:0]        offset,
    output logic [LANES*LANE_W-1:0] word_out
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LOG2L-1:0] w_src;

        assign w_src = LOG2L'(lane_idx(32'(mult), 32'(offset), gi, LANES));
        assign word_out[gi*LANE_W +: LANE_W] = word_in[w_src*LANE_W +: LANE_W];
    end

endmodule
`default_nettype wire

// File: rtl/perm_shuffle_engine.sv
`default_nettype none
// ============================================================================
//  Module      : perm_shuffle_engine
//  Description : Multi-round lane-permutation engine with LFSR-derived keys
//                and a per-word rotation counter, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module perm_shuffle_engine
    import perm_shuffle_pkg::*;
#(
    parameter  int LANES      = 16,
    parameter  int LANE_W     = 4,
    parameter  int MAX_ROUNDS = 8,
    localparam int LOG2L      = $clog2(LANES),
    localparam int RND_W      = $clog2(MAX_ROUNDS + 1),
    localparam int DATA_W     = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [15:0]       seed_val,
    input  logic [RND_W-1:0]  cfg_rounds,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_e              r_state;
    logic [DATA_W-1:0]   r_work;
    logic [RND_W-1:0]    r_rounds_left;
    logic [15:0]         r_lfsr;
    logic [LOG2L-1:0]    r_shift;

    logic [LOG2L-1:0]    w_mult;
    logic [LOG2L-1:0]    w_offset;
    logic [RND_W-1:0]    w_eff_rounds;
    logic [DATA_W-1:0]   w_round_out;

    // Forcing the LSB high keeps the multiplier odd, hence the map bijective.
    assign w_mult   = {r_lfsr[LOG2L-2:0], 1'b1};
    assign w_offset = r_lfsr[2*LOG2L-1:LOG2L] + r_shift;

    always_comb begin
        w_eff_rounds = cfg_rounds;
        if (cfg_rounds == '0) begin
            w_eff_rounds = RND_W'(1);
        end else if (cfg_rounds > RND_W'(MAX_ROUNDS)) begin
            w_eff_rounds = RND_W'(MAX_ROUNDS);
        end
    end

    perm_affine_round #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_round (
        .word_in  (r_work),
        .mult     (w_mult),
        .offset   (w_offset),
        .word_out (w_round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_work        <= '0;
            r_rounds_left <= '0;
            r_lfsr        <= LFSR_SEED_DEFAULT;
            r_shift       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A same-cycle seed load lands before the first RUN round,
                    // so it applies to the word accepted alongside it.
                    if (seed_load) begin
                        r_lfsr <= (seed_val == 16'h0000) ? LFSR_SEED_DEFAULT : seed_val;
                    end
                    if (in_valid) begin
                        r_work        <= in_data;
                        r_rounds_left <= w_eff_rounds;
                        r_state       <= RUN;
                    end
                end
                RUN: begin
                    r_work        <= w_round_out;
                    r_lfsr        <= lfsr_step(r_lfsr);
                    r_rounds_left <= r_rounds_left - RND_W'(1);
                    if (r_rounds_left == RND_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_shift <= r_shift + LOG2L'(1);
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign out_data  = (r_state == DONE) ? r_work : '0;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_perm_shuffle_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perm_shuffle_engine
//  Description : Directed self-checking bench for perm_shuffle_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_perm_shuffle_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed_val = 16'h0000;
    logic [3:0]  cfg_rounds = 4'd1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tb_lfsr  = 16'h0001;
    logic [3:0]  tb_shift = 4'd0;

    localparam logic [63:0] RAMP = 64'hFEDCBA9876543210;

    perm_shuffle_engine #(
        .LANES      (16),
        .LANE_W     (4),
        .MAX_ROUNDS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed_val   (seed_val),
        .cfg_rounds (cfg_rounds),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int eff_of(input logic [3:0] r);
        if (r == 4'd0) return 1;
        if (r > 4'd8) return 8;
        return int'(r);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    function automatic logic [63:0] model_perm(input logic [63:0] d, input logic [15:0] lf,
                                               input logic [3:0] sh, input int rounds);
        logic [63:0] w;
        logic [63:0] nw;
        logic [15:0] l;
        int m, k, src;
        w  = d;
        nw = '0;
        l  = lf;
        for (int r = 0; r < rounds; r++) begin
            m = int'({l[2:0], 1'b1});
            k = (int'(l[7:4]) + int'(sh)) % 16;
            for (int i = 0; i < 16; i++) begin
                src = (m * i + k) % 16;
                nw[i*4 +: 4] = w[src*4 +: 4];
            end
            w = nw;
            l = lfsr_next(l);
        end
        return w;
    endfunction

    // Drives one accept from IDLE and advances the bench's own LFSR model.
    task automatic start_word(input logic [63:0] d, input logic [3:0] rounds, input logic sload,
                              input logic [15:0] sval, output logic [63:0] exp);
        int e;
        if (sload) tb_lfsr = (sval == 16'h0000) ? 16'h0001 : sval;
        e   = eff_of(rounds);
        exp = model_perm(d, tb_lfsr, tb_shift, e);
        for (int r = 0; r < e; r++) tb_lfsr = lfsr_next(tb_lfsr);
        in_data    = d;
        cfg_rounds = rounds;
        seed_load  = sload;
        seed_val   = sval;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        seed_load  = 1'b0;
        in_data    = 64'h0;
        cfg_rounds = 4'd0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tb_shift  = tb_shift + 4'd1;
    endtask

    task automatic test_reset();
        logic [63:0] exp;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b expected 0", busy); end

        // Disturb lfsr and shift so the abort below has something to restore.
        start_word(RAMP, 4'd3, 1'b1, 16'hACE1, exp);
        wait_done(lat);
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL pre_abort_word: got %h expected %h", out_data, exp); end
        finish_word();

        start_word(RAMP, 4'd8, 1'b0, 16'h0, exp);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_release_in_ready: got %b expected 1", in_ready); end
        tb_lfsr  = 16'h0001;
        tb_shift = 4'd0;
    endtask

    // lfsr and shift are back at reset values, so the hand-derived result applies.
    task automatic test_single_round();
        logic [63:0] exp;
        logic [15:0] seen;
        int lat;
        start_word(RAMP, 4'd1, 1'b0, 16'h0, exp);
        wait_done(lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
        n_checks++; if (out_data[15:0] !== 16'h9630) begin n_fail++; $display("FAIL single_low16: got %h expected 9630", out_data[15:0]); end
        n_checks++; if (out_data !== 64'hDA741EB852FC9630) begin n_fail++; $display("FAIL single_word: got %h expected DA741EB852FC9630", out_data); end
        seen = '0;
        for (int i = 0; i < 16; i++) seen[out_data[i*4 +: 4]] = 1'b1;
        n_checks++; if (seen !== 16'hFFFF) begin n_fail++; $display("FAIL single_is_perm: got %h expected FFFF", seen); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_done_in_ready: got %b expected 0", in_ready); end
        finish_word();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_back_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_shift_wrap();
        logic [63:0] exp;
        logic [63:0] first;
        int lat;
        first = '0;
        for (int n = 0; n < 17; n++) begin
            start_word(RAMP, 4'd1, 1'b1, 16'h0001, exp);
            wait_done(lat);
            n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL wrap_word%0d: got %h expected %h", n, out_data, exp); end
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wrap_latency%0d: got %0d expected 2", n, lat); end
            if (n == 0) first = out_data;
            if (n == 16) begin
                n_checks++; if (out_data !== first) begin n_fail++; $display("FAIL wrap_16_eq_0: got %h expected %h", out_data, first); end
            end
            finish_word();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp;
        logic [63:0] snap;
        int lat;
        start_word(64'h0123456789ABCDEF, 4'd2, 1'b0, 16'h0, exp);
        wait_done(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d expected 3", lat); end
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL bp_word: got %h expected %h", out_data, exp); end
        snap     = exp;
        in_valid = 1'b1;
        in_data  = 64'h5555AAAA5555AAAA;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b expected 1", c, out_valid); end
            n_checks++; if (out_data !== snap) begin n_fail++; $display("FAIL bp_data_c%0d: got %h expected %h", c, out_data, snap); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready); end
        end
        in_valid = 1'b0;
        in_data  = 64'h0;
        finish_word();
        // A stalled DONE must leave lfsr and shift alone; the next word shows it.
        start_word(RAMP, 4'd1, 1'b0, 16'h0, exp);
        wait_done(lat);
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL bp_after_word: got %h expected %h", out_data, exp); end
        finish_word();
    endtask

    task automatic test_multi_clamp();
        logic [63:0] exp;
        int lat;
        start_word(64'h0F1E2D3C4B5A6978, 4'd0, 1'b1, 16'h5A5A, exp);
        wait_done(lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL r0_latency: got %0d expected 2", lat); end
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL r0_word: got %h expected %h", out_data, exp); end
        finish_word();

        start_word(64'h13579BDF02468ACE, 4'd15, 1'b1, 16'hC3D2, exp);
        wait_done(lat);
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL r15_latency: got %0d expected 9", lat); end
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL r15_word: got %h expected %h", out_data, exp); end
        finish_word();

        start_word(RAMP, 4'd5, 1'b0, 16'h0, exp);
        wait_done(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL r5_latency: got %0d expected 6", lat); end
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL r5_word: got %h expected %h", out_data, exp); end
        finish_word();

        start_word(64'hA5A5F00F3CC3E11E, 4'd8, 1'b0, 16'h0, exp);
        wait_done(lat);
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL r8_latency: got %0d expected 9", lat); end
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL r8_word: got %h expected %h", out_data, exp); end
        finish_word();
    endtask

    task automatic test_seed_collision();
        logic [63:0] exp;
        int lat;
        start_word(RAMP, 4'd1, 1'b1, 16'h0000, exp);
        wait_done(lat);
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL seed0_word: got %h expected %h", out_data, exp); end
        finish_word();

        start_word(64'h89ABCDEF01234567, 4'd4, 1'b0, 16'h0, exp);
        seed_load = 1'b1;
        seed_val  = 16'h1234;
        wait_done(lat);
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL run_seed_ignored: got %h expected %h", out_data, exp); end
        seed_load = 1'b0;
        finish_word();

        start_word(RAMP, 4'd3, 1'b0, 16'h0, exp);
        wait_done(lat);
        n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL post_run_seed_word: got %h expected %h", out_data, exp); end
        finish_word();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_round();
        test_shift_wrap();
        test_backpressure();
        test_multi_clamp();
        test_seed_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
